fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage sitting directly upstream of the instruction decoder. Holds the program counter, drives the instruction memory address, and presents each fetched 9-bit instruction to the decoder in the same cycle. It consumes the decoder's `pc_jmp_en`, `pc_jmp_abs` and 4-bit LUT pointer to pick the next PC from a writable jump-target table. It also sequences program start and halt through a start/done handshake.

## Interface
Parameters:
- `PC_W`, 10, program counter and instruction memory address width
- `INSTR_W`, 9, instruction width
- `LUT_DEPTH`, 16, jump-target table entries (pointer width = 4)

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  clock
- `rst_n`  in  1  synchronous active-low reset
- `start`  in  1  begin program from PC 0 (honoured in IDLE/DONE only)
- `pc_jmp_en`  in  1  decoder: take jump this cycle
- `pc_jmp_abs`  in  1  decoder: 1 = absolute target, 0 = PC-relative
- `lut_ptr`  in  4  decoder: jump-table index
- `lut_wr_en`  in  1  write a jump-table entry
- `lut_wr_addr`  in  4  entry index to write
- `lut_wr_data`  in  PC_W  target or signed offset to store
- `imem_addr`  out  PC_W  instruction memory address (= `pc`)
- `imem_data`  in  INSTR_W  instruction memory read data (combinational)
- `instr`  out  INSTR_W  instruction to decoder
- `pc`  out  PC_W  current program counter
- `running`  out  1  high in RUN
- `done`  out  1  high in DONE

## Operation
- FSM states: IDLE, RUN, DONE.
- Reset: state IDLE, `pc` 0, all LUT entries 0, `running` 0, `done` 0. Reset mid-RUN aborts immediately and returns to IDLE.
- IDLE: `pc` holds 0. `start`=1 moves to RUN with `pc` 0.
- RUN: `instr` = `imem_data`. Next-PC priority:
  - `imem_data` == HALT (9'h1FF): go to DONE; `pc` holds.
  - `pc_jmp_en`=1 and `pc_jmp_abs`=1: `pc` ← `lut[lut_ptr]`.
  - `pc_jmp_en`=1 and `pc_jmp_abs`=0: `pc` ← `pc` + `lut[lut_ptr]`. The entry is treated as two's complement; the sum wraps mod 2^PC_W.
  - Otherwise `pc` ← `pc`+1. It wraps from 2^PC_W−1 to 0.
- DONE: `done`=1 and `pc` holds. `start`=1 returns to RUN with `pc` 0 and drops `done` on the next cycle.
- `start` in RUN is ignored.
- Outside RUN, `instr` = 9'h000. Jump inputs are ignored outside RUN.
- LUT writes: accepted in IDLE and DONE. In RUN they are ignored, so no read/write collision exists.
- A write and `start` in the same cycle are both honoured. The written value is visible from the first RUN cycle.

## Timing
- The PC register updates on the rising `clk` edge.
- `imem_addr`→`instr` is combinational; the decoder sees the instruction at PC in the same cycle.
- Jump resolution takes zero bubbles: a taken jump's target is fetched on the cycle after the jump instruction.
- HALT is detected in the cycle it is presented. `done` rises on the next edge.
- `running` and `done` are registered state decodes and are never both high.

## Configuration
- `FETCH_JUMP_CNT_EN` defined:
  - Adds output `jump_cnt` [15:0], which counts cycles in RUN with `pc_jmp_en`=1.
  - The count clears to 0 on reset and on the accepted `start`.
  - It saturates at 16'hFFFF and holds its value in DONE.
- `FETCH_JUMP_CNT_EN` undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Package `fetch_pkg` holds:
  - the state enum (IDLE/RUN/DONE);
  - `HALT_INSTR` = 9'h1FF;
  - the default `PC_W`, `INSTR_W` and `LUT_DEPTH` constants.
- Sub-module `jump_lut`: LUT_DEPTH×PC_W register file with one synchronous write port, one combinational read port and synchronous reset-to-zero.
- The FSM, PC register and optional counter live in `fetch_unit`.

## Test plan
- Reset, then `start`, with imem holding 8 non-jump instructions then HALT at address 8 → `pc` steps 0..8, `done`=1 one cycle after `pc`=8, and `pc` holds at 8.
- In IDLE, write `lut[3]`=10'h040; at `pc`=5 assert `pc_jmp_en`=1, `pc_jmp_abs`=1, `lut_ptr`=3 → next `pc`=0x040.
- Write `lut[1]`=10'h3FC (−4); relative jump at `pc`=10 → `pc`=6. Write `lut[2]`=10'h005; relative jump at `pc`=10'h3FE → `pc`=3 (wrap).
- `lut_wr_en` in RUN targeting entry 3 with 10'h111, then jump via entry 3 → target is still the pre-RUN value 0x040.
- `rst_n` low for one cycle at `pc`=20 in RUN → IDLE, `pc`=0, `instr`=0, LUT cleared; a later `start` restarts at 0.
- With `FETCH_JUMP_CNT_EN`: 3 taken jumps then HALT → `jump_cnt`=3 held in DONE; a new `start` resets it to 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_e : fetch sequencer states (idle, running, halted/done)
//   HALT_INSTR    : instruction encoding that stops the program
//   PcWidth, InstrWidth, LutDepth : default parameter values for fetch_unit
package fetch_pkg;

  localparam int unsigned PcWidth    = 10;
  localparam int unsigned InstrWidth = 9;
  localparam int unsigned LutDepth   = 16;

  localparam logic [8:0] HALT_INSTR = 9'h1FF;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/jump_lut.sv
// Jump-target table: Depth x Width register file.
//   clk_i, rst_ni : clock, synchronous active-low reset (clears every entry)
//   wr_en_i, wr_addr_i, wr_data_i : synchronous write port
//   rd_addr_i, rd_data_o          : combinational read port
module jump_lut #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 10,
  parameter int unsigned AddrW = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [AddrW-1:0] wr_addr_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic [AddrW-1:0] rd_addr_i,
  output logic [Width-1:0] rd_data_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: program counter, instruction memory addressing and
// start/halt sequencing. Next PC is chosen from sequential increment or a jump
// through a writable target table (absolute or PC-relative).
//   clk, rst_n        : clock, synchronous active-low reset
//   start             : begin program at PC 0 (accepted in idle/done only)
//   pc_jmp_en/abs     : decoder jump request and mode (1 = absolute)
//   lut_ptr           : jump-table index used by the jump
//   lut_wr_*          : jump-table write port (ignored while running)
//   imem_addr/data    : instruction memory address and combinational read data
//   instr             : instruction to decoder (zero when not running)
//   pc, running, done : program counter and registered state decodes
//   jump_cnt          : taken-jump cycle counter, present only when
//                       FETCH_JUMP_CNT_EN is defined
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W      = PcWidth,
  parameter int unsigned INSTR_W   = InstrWidth,
  parameter int unsigned LUT_DEPTH = LutDepth
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               pc_jmp_en,
  input  logic               pc_jmp_abs,
  input  logic [3:0]         lut_ptr,
  input  logic               lut_wr_en,
  input  logic [3:0]         lut_wr_addr,
  input  logic [PC_W-1:0]    lut_wr_data,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc,
  output logic               running,
  output logic               done
`ifdef FETCH_JUMP_CNT_EN
  ,
  output logic [15:0]        jump_cnt
`endif
);

  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   lut_rd_data;
  logic              in_run;
  logic              is_halt;
  logic              start_accept;

  assign in_run       = (state_q == StRun);
  assign is_halt      = (imem_data == INSTR_W'(HALT_INSTR));
  assign start_accept = start && ((state_q == StIdle) || (state_q == StDone));

  // Writes are blocked in RUN so the table is stable while jumps read it.
  jump_lut #(
    .Depth(LUT_DEPTH),
    .Width(PC_W),
    .AddrW(4)
  ) u_jump_lut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .wr_en_i  (lut_wr_en && !in_run),
    .wr_addr_i(lut_wr_addr),
    .wr_data_i(lut_wr_data),
    .rd_addr_i(lut_ptr),
    .rd_data_o(lut_rd_data)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      StIdle: begin
        pc_d = '0;
        if (start) state_d = StRun;
      end
      StRun: begin
        if (is_halt) begin
          state_d = StDone;
        end else if (pc_jmp_en) begin
          // Relative entries are two's complement; unsigned add wraps correctly.
          pc_d = pc_jmp_abs ? lut_rd_data : pc_q + lut_rd_data;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      StDone: begin
        if (start) begin
          state_d = StRun;
          pc_d    = '0;
        end
      end
      default: begin
        state_d = StIdle;
        pc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign instr     = in_run ? imem_data : '0;
  assign running   = in_run;
  assign done      = (state_q == StDone);

`ifdef FETCH_JUMP_CNT_EN
  logic [15:0] jump_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      jump_cnt_q <= '0;
    end else if (start_accept) begin
      jump_cnt_q <= '0;
    end else if (in_run && pc_jmp_en && (jump_cnt_q != 16'hFFFF)) begin
      jump_cnt_q <= jump_cnt_q + 16'd1;
    end
  end

  assign jump_cnt = jump_cnt_q;
`else
  logic unused_start_accept;
  assign unused_start_accept = start_accept;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       pc_jmp_en;
  logic       pc_jmp_abs;
  logic [3:0] lut_ptr;
  logic       lut_wr_en;
  logic [3:0] lut_wr_addr;
  logic [9:0] lut_wr_data;
  logic [9:0] imem_addr;
  logic [8:0] imem_data;
  logic [8:0] instr;
  logic [9:0] pc;
  logic       running;
  logic       done;
`ifdef FETCH_JUMP_CNT_EN
  logic [15:0] jump_cnt;
`endif

  logic [8:0] imem [1024];
  assign imem_data = imem[imem_addr];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pc_jmp_en  (pc_jmp_en),
    .pc_jmp_abs (pc_jmp_abs),
    .lut_ptr    (lut_ptr),
    .lut_wr_en  (lut_wr_en),
    .lut_wr_addr(lut_wr_addr),
    .lut_wr_data(lut_wr_data),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .instr      (instr),
    .pc         (pc),
    .running    (running),
    .done       (done)
`ifdef FETCH_JUMP_CNT_EN
    ,
    .jump_cnt   (jump_cnt)
`endif
  );

  typedef struct {
    string       name;
    logic [9:0]  pc;
    logic        run;
    logic        dn;
    logic [8:0]  instr;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Expected outputs for the cycle following the edge just taken.
  task automatic cyc(input string name, input logic [9:0] epc, input logic erun,
                     input logic edn, input logic [15:0] ecnt);
    exp_t e;
    @(posedge clk);
    #1;
    e.name  = name;
    e.pc    = epc;
    e.run   = erun;
    e.dn    = edn;
    e.instr = erun ? imem[epc] : 9'h000;
    e.cnt   = ecnt;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input string field, input logic [15:0] got,
                     input logic [15:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s.%s got=%h want=%h", name, field, got, want);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.name, "pc", 16'(pc), 16'(e.pc));
      chk(e.name, "running", 16'(running), 16'(e.run));
      chk(e.name, "done", 16'(done), 16'(e.dn));
      chk(e.name, "instr", 16'(instr), 16'(e.instr));
`ifdef FETCH_JUMP_CNT_EN
      chk(e.name, "jump_cnt", jump_cnt, e.cnt);
`endif
    end
  end

  task automatic lut_write(input logic [3:0] a, input logic [9:0] d);
    lut_wr_en   = 1'b1;
    lut_wr_addr = a;
    lut_wr_data = d;
  endtask

  task automatic jump(input logic abs, input logic [3:0] ptr);
    pc_jmp_en  = 1'b1;
    pc_jmp_abs = abs;
    lut_ptr    = ptr;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) imem[i] = {1'b0, i[7:0]};
    rst_n = 1'b0; start = 1'b0; pc_jmp_en = 1'b0; pc_jmp_abs = 1'b0; lut_ptr = '0;
    lut_wr_en = 1'b0; lut_wr_addr = '0; lut_wr_data = '0;

    // Straight-line program halting at address 8.
    cyc("reset", 10'd0, 1'b0, 1'b0, 16'd0);
    cyc("reset", 10'd0, 1'b0, 1'b0, 16'd0);
    rst_n = 1'b1;
    cyc("idle", 10'd0, 1'b0, 1'b0, 16'd0);
    imem[8] = 9'h1FF;
    start = 1'b1;
    cyc("start", 10'd0, 1'b1, 1'b0, 16'd0);
    start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (i == 3) start = 1'b1;  // start is ignored in RUN
      cyc("seq", 10'(i), 1'b1, 1'b0, 16'd0);
      start = 1'b0;
    end
    cyc("halt", 10'd8, 1'b0, 1'b1, 16'd0);
    cyc("hold", 10'd8, 1'b0, 1'b1, 16'd0);
    imem[8] = 9'h008;

    // Jump table setup in IDLE; last write shares the cycle with start.
    rst_n = 1'b0;
    cyc("reset2", 10'd0, 1'b0, 1'b0, 16'd0);
    rst_n = 1'b1;
    lut_write(4'd3, 10'h040); cyc("wr3", 10'd0, 1'b0, 1'b0, 16'd0);
    lut_write(4'd1, 10'h3FC); cyc("wr1", 10'd0, 1'b0, 1'b0, 16'd0);
    lut_write(4'd0, 10'h00A); cyc("wr0", 10'd0, 1'b0, 1'b0, 16'd0);
    lut_write(4'd4, 10'h3FE); cyc("wr4", 10'd0, 1'b0, 1'b0, 16'd0);
    lut_write(4'd2, 10'h005); start = 1'b1;
    cyc("wr2_start", 10'd0, 1'b1, 1'b0, 16'd0);
    lut_wr_en = 1'b0; start = 1'b0;
    for (int i = 1; i <= 5; i++) cyc("seq2", 10'(i), 1'b1, 1'b0, 16'd0);
    jump(1'b1, 4'd3); cyc("abs_5_to_40", 10'h040, 1'b1, 1'b0, 16'd1);
    jump(1'b1, 4'd0); cyc("abs_to_0a", 10'h00A, 1'b1, 1'b0, 16'd2);
    jump(1'b0, 4'd1); cyc("rel_10_m4", 10'd6, 1'b1, 1'b0, 16'd3);
    jump(1'b1, 4'd4); cyc("abs_to_3fe", 10'h3FE, 1'b1, 1'b0, 16'd4);
    jump(1'b0, 4'd2); cyc("rel_wrap", 10'd3, 1'b1, 1'b0, 16'd5);
    pc_jmp_en = 1'b0;
    lut_write(4'd3, 10'h111); cyc("wr_in_run", 10'd4, 1'b1, 1'b0, 16'd5);
    lut_wr_en = 1'b0;
    jump(1'b1, 4'd3); cyc("lut_kept", 10'h040, 1'b1, 1'b0, 16'd6);
    pc_jmp_en = 1'b0;
    imem[10'h042] = 9'h1FF;
    cyc("seq3", 10'h041, 1'b1, 1'b0, 16'd6);
    cyc("seq3", 10'h042, 1'b1, 1'b0, 16'd6);
    cyc("halt2", 10'h042, 1'b0, 1'b1, 16'd6);
    jump(1'b1, 4'd3); cyc("done_jmp_ign", 10'h042, 1'b0, 1'b1, 16'd6);
    pc_jmp_en = 1'b0;
    imem[10'h042] = 9'h042;

    // Restart from DONE with a same-cycle write used on the first RUN cycle.
    lut_write(4'd5, 10'h3FF); start = 1'b1;
    cyc("restart", 10'd0, 1'b1, 1'b0, 16'd0);
    lut_wr_en = 1'b0; start = 1'b0;
    jump(1'b1, 4'd5); cyc("first_cyc_jmp", 10'h3FF, 1'b1, 1'b0, 16'd1);
    pc_jmp_en = 1'b0;
    cyc("inc_wrap", 10'd0, 1'b1, 1'b0, 16'd1);
    for (int i = 1; i <= 20; i++) cyc("seq4", 10'(i), 1'b1, 1'b0, 16'd1);

    // Reset mid-RUN, then confirm the table was cleared.
    rst_n = 1'b0;
    cyc("reset_run", 10'd0, 1'b0, 1'b0, 16'd0);
    rst_n = 1'b1;
    cyc("idle3", 10'd0, 1'b0, 1'b0, 16'd0);
    start = 1'b1;
    cyc("start3", 10'd0, 1'b1, 1'b0, 16'd0);
    start = 1'b0;
    jump(1'b1, 4'd3); cyc("lut_cleared", 10'd0, 1'b1, 1'b0, 16'd1);
    pc_jmp_en = 1'b0;
    cyc("seq5", 10'd1, 1'b1, 1'b0, 16'd1);
    cyc("seq5", 10'd2, 1'b1, 1'b0, 16'd1);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
